button_load_sequencer: RTL and testbench



---
 rtl/button_load_sequencer.sv | 162 ++++++++++++++++
 tb/tb_button_load_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/button_load_sequencer.sv
// button_load_sequencer: synchronizes BTN/SW, debounces BTN and emits one registered LOAD/DIN per press.
// Optional macro AUTO_REPEAT_EN adds periodic repeat loads while the button stays held.
module button_load_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN,
  input  logic [3:0] SW,
  output logic [3:0] DIN,
  output logic       LOAD,
  output logic       PRESSED,
  output logic [7:0] LOAD_COUNT
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_meta_q, btn_s_q;
  logic [3:0]    sw_meta_q, sw_s_q;
  logic [3:0]    din_q, din_d;
  logic          load_q, load_d;
  logic          pressed_q, pressed_d;
  logic [7:0]    count_q, count_d;
`ifdef AUTO_REPEAT_EN
  logic [CW-1:0] rep_q, rep_d;
`endif

  // Two-flop synchronizers for the raw button and switches
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= 4'h0;
      sw_s_q     <= 4'h0;
    end else begin
      btn_meta_q <= BTN;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= SW;
      sw_s_q     <= sw_meta_q;
    end
  end

  // FSM state, debounce counter and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      din_q     <= 4'h0;
      load_q    <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= 8'h00;
`ifdef AUTO_REPEAT_EN
      rep_q     <= {CW{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      load_q    <= load_d;
      pressed_q <= pressed_d;
      count_q   <= count_d;
`ifdef AUTO_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  // Next-state, debounce counting and load capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    din_d   = din_q;
    count_d = count_q;
`ifdef AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = DB_PRESS;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      DB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          load_d  = 1'b1;
          din_d   = sw_s_q;
          count_d = count_q + 8'd1;
`ifdef AUTO_REPEAT_EN
          rep_d   = {CW{1'b0}};
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = DB_RELEASE;
          cnt_d   = {CW{1'b0}};
        end else begin
`ifdef AUTO_REPEAT_EN
          // Repeat counter only advances while the button is stably held
          if (rep_q == REP_LAST) begin
            load_d  = 1'b1;
            din_d   = sw_s_q;
            count_d = count_q + 8'd1;
            rep_d   = {CW{1'b0}};
          end else begin
            rep_d = rep_q + CW'(1);
          end
`else
          state_d = HELD;
`endif
        end
      end
      DB_RELEASE: begin
        if (btn_s_q) begin
          state_d = HELD;
`ifdef AUTO_REPEAT_EN
          rep_d   = {CW{1'b0}};
`endif
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    pressed_d = (state_d == HELD) || (state_d == DB_RELEASE);
  end

  assign DIN        = din_q;
  assign LOAD       = load_q;
  assign PRESSED    = pressed_q;
  assign LOAD_COUNT = count_q;

endmodule

// File: tb/tb_button_load_sequencer.sv
// Self-checking bench for button_load_sequencer: directed scenarios plus random button/switch
// activity, compared every cycle against a run-length debounce reference model.
module tb_button_load_sequencer;

  localparam int D = 4;
  localparam int R = 8;

  logic       CLK;
  logic       RST_N;
  logic       BTN;
  logic [3:0] SW;
  logic [3:0] DIN;
  logic       LOAD;
  logic       PRESSED;
  logic [7:0] LOAD_COUNT;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic       m_b1, m_b2;
  logic [3:0] m_sw1, m_sw2;
  logic       m_pressed;
  int         m_run;
  int         m_rep;
  logic       m_load;
  logic [3:0] m_din;
  int         m_count;

  button_load_sequencer #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN(BTN), .SW(SW),
    .DIN(DIN), .LOAD(LOAD), .PRESSED(PRESSED), .LOAD_COUNT(LOAD_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_b1 = 1'b0; m_b2 = 1'b0; m_sw1 = 4'h0; m_sw2 = 4'h0;
    m_pressed = 1'b0; m_run = 0; m_rep = 0;
    m_load = 1'b0; m_din = 4'h0; m_count = 0;
  endtask

  // A press is accepted after D+1 consecutive synchronized highs, a release after D+1 lows.
  task automatic model_edge(input logic b, input logic [3:0] s);
    logic       bs;
    logic [3:0] ss;
    bs = m_b2; ss = m_sw2;
    m_b2 = m_b1; m_b1 = b;
    m_sw2 = m_sw1; m_sw1 = s;
    m_load = 1'b0;
    if (!m_pressed) begin
      m_run = bs ? m_run + 1 : 0;
      if (m_run == D + 1) begin
        m_pressed = 1'b1; m_run = 0; m_rep = 0;
        m_load = 1'b1; m_din = ss; m_count = (m_count + 1) % 256;
      end
    end else begin
      if (!bs) begin
        m_run = m_run + 1;
        if (m_run == D + 1) begin
          m_pressed = 1'b0; m_run = 0;
        end
      end else begin
`ifdef AUTO_REPEAT_EN
        if (m_run > 0) m_rep = 0;
        else begin
          m_rep = m_rep + 1;
          if (m_rep == R) begin
            m_rep = 0; m_load = 1'b1; m_din = ss; m_count = (m_count + 1) % 256;
          end
        end
`endif
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic b, input logic [3:0] s);
    BTN = b; SW = s;
    @(posedge CLK);
    model_edge(b, s);
    #1;
    check_eq("load", {31'd0, LOAD}, {31'd0, m_load});
    check_eq("din", {28'd0, DIN}, {28'd0, m_din});
    check_eq("pressed", {31'd0, PRESSED}, {31'd0, m_pressed});
    check_eq("load_count", {24'd0, LOAD_COUNT}, m_count);
  endtask

  task automatic async_reset_check();
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_eq("rst_load", {31'd0, LOAD}, 32'd0);
    check_eq("rst_din", {28'd0, DIN}, 32'd0);
    check_eq("rst_count", {24'd0, LOAD_COUNT}, 32'd0);
    check_eq("rst_pressed", {31'd0, PRESSED}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    int first_load;
    int cnt_before;
    logic [3:0] sw_v;
    RST_N = 1'b0; BTN = 1'b0; SW = 4'h0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_eq("init_count", {24'd0, LOAD_COUNT}, 32'd0);
    check_eq("init_din", {28'd0, DIN}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Clean press latency: LOAD in the cycle after edge 3+D
    first_load = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 4'hA);
      if (LOAD && first_load < 0) first_load = i;
    end
    check_eq("latency", first_load, 3 + D);
    check_eq("din_after_press", {28'd0, DIN}, 32'hA);
    for (int i = 0; i < 12; i++) step(1'b0, 4'h6);
    check_eq("released", {31'd0, PRESSED}, 32'd0);

    // Bounce: high 2, low 1, six times, never long enough
    cnt_before = m_count;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'h3); step(1'b1, 4'h3); step(1'b0, 4'h3);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 4'h3);
    check_eq("bounce_count", {24'd0, LOAD_COUNT}, cnt_before);

    // Release glitch during hold returns to HELD without a second load
    for (int i = 0; i < 10; i++) step(1'b1, 4'h7);
    cnt_before = m_count;
    step(1'b0, 4'h7); step(1'b0, 4'h7);
    for (int i = 0; i < 5; i++) step(1'b1, 4'h7);
    check_eq("glitch_pressed", {31'd0, PRESSED}, 32'd1);
    check_eq("glitch_count", {24'd0, LOAD_COUNT}, cnt_before);
    for (int i = 0; i < 12; i++) step(1'b0, 4'h7);

    // Asynchronous reset mid-press, then the still-held button is a new press
    for (int i = 0; i < 9; i++) step(1'b1, 4'hF);
    async_reset_check();
    for (int i = 0; i < 12; i++) step(1'b1, 4'hF);
    check_eq("post_reset_count", {24'd0, LOAD_COUNT}, 32'd1);
    for (int i = 0; i < 12; i++) step(1'b0, 4'hF);

`ifdef AUTO_REPEAT_EN
    // Auto-repeat with the switch word changing mid-hold
    async_reset_check();
    for (int i = 0; i < 7; i++) step(1'b1, 4'h3);
    for (int i = 0; i < 12; i++) step(1'b1, 4'h3);
    for (int i = 0; i < 19; i++) step(1'b1, 4'h5);
    check_eq("repeat_count", {24'd0, LOAD_COUNT}, 32'd4);
    for (int i = 0; i < 12; i++) step(1'b0, 4'h5);
`endif

    // 256 clean presses: counter wraps back to its starting value
    cnt_before = m_count;
    for (int p = 0; p < 256; p++) begin
      sw_v = 4'(p % 16);
      for (int i = 0; i < D + 4; i++) step(1'b1, sw_v);
      check_eq("wrap_din", {28'd0, DIN}, {28'd0, sw_v});
      for (int i = 0; i < D + 4; i++) step(1'b0, sw_v);
    end
    check_eq("wrap_count", {24'd0, LOAD_COUNT}, cnt_before);

    // Random button activity with random switch words
    for (int it = 0; it < 250; it++) begin
      int len;
      logic lvl;
      lvl = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 2)) == 0) ? int'($urandom_range(1, D)) : int'($urandom_range(1, D + 20));
      for (int i = 0; i < len; i++) begin
        step(lvl, 4'($urandom_range(0, 15)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
